// File: rtl/reg_bank_arbiter_if.sv
// Bus bundle for the two-requester register bank arbiter.
// The master side is the pair of requesters; the slave side is the arbiter.
interface reg_bank_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic             rw0;
    logic             rw1;
    logic [1:0]       addr0;
    logic [1:0]       addr1;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             ack0;
    logic             ack1;
    logic [1:0]       gnt;
    logic [WIDTH-1:0] q;
    logic             en;
    logic             busy;

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, d0, d1,
        input  ack0, ack1, gnt, q, en, busy
    );

    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, d0, d1,
        output ack0, ack1, gnt, q, en, busy
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a small register bank.
// Each transaction runs IDLE -> STROBE -> DONE -> IDLE with fixed latency;
// operands are captured at grant so requesters may change them afterwards.
// All outputs are registered and derived from the next state.
module reg_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_bank_arbiter_if.slave    bus
);

    localparam int AW = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STROBE = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;

    // Arbitration and captured transaction
    logic             ptr_r;      // 0: requester 0 wins a tie
    logic             owner_r;
    logic             rw_r;
    logic [AW-1:0]    addr_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] bank_r [DEPTH];

    logic             take_s;
    logic             win_s;
    logic             sel_rw_s;
    logic [AW-1:0]    sel_addr_s;
    logic [WIDTH-1:0] sel_d_s;
    logic [WIDTH-1:0] rd_data_s;

    // Registered outputs and their next values
    logic [1:0]       gnt_r;
    logic [1:0]       gnt_s;
    logic             en_r;
    logic             en_s;
    logic             busy_r;
    logic             busy_s;
    logic             ack0_r;
    logic             ack0_s;
    logic             ack1_r;
    logic             ack1_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_s;

    function automatic logic [1:0] owner_onehot(input logic who);
        logic [1:0] oh;
        if (who) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

    // Pick the winner among the requests seen at this edge
    always_comb begin
        take_s = 1'b0;
        win_s  = ptr_r;
        if (bus.req0 && bus.req1) begin
            take_s = 1'b1;
            win_s  = ptr_r;
        end else if (bus.req0) begin
            take_s = 1'b1;
            win_s  = 1'b0;
        end else if (bus.req1) begin
            take_s = 1'b1;
            win_s  = 1'b1;
        end else begin
            take_s = 1'b0;
            win_s  = ptr_r;
        end
    end

    // Route the winner's operands toward the holding registers
    always_comb begin
        sel_rw_s   = 1'b0;
        sel_addr_s = {AW{1'b0}};
        sel_d_s    = {WIDTH{1'b0}};
        if (win_s) begin
            sel_rw_s   = bus.rw1;
            sel_addr_s = bus.addr1;
            sel_d_s    = bus.d1;
        end else begin
            sel_rw_s   = bus.rw0;
            sel_addr_s = bus.addr0;
            sel_d_s    = bus.d0;
        end
    end

    // Next-state logic: a fixed three-step walk once a request is taken
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    state_s = STROBE;
                end else begin
                    state_s = IDLE;
                end
            end
            STROBE:  state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Bank read port addressed by the captured address
    always_comb begin
        rd_data_s = bank_r[addr_r];
    end

    // Output values for the state being entered at the next edge
    always_comb begin
        gnt_s  = 2'b00;
        en_s   = 1'b0;
        busy_s = 1'b0;
        ack0_s = 1'b0;
        ack1_s = 1'b0;
        q_s    = {WIDTH{1'b0}};
        case (state_s)
            IDLE: begin
                gnt_s  = 2'b00;
                busy_s = 1'b0;
            end
            STROBE: begin
                // STROBE is only ever entered from IDLE, where the winner is live
                gnt_s  = owner_onehot(win_s);
                en_s   = 1'b1;
                busy_s = 1'b1;
            end
            DONE: begin
                gnt_s  = owner_onehot(owner_r);
                busy_s = 1'b1;
                ack0_s = ~owner_r;
                ack1_s = owner_r;
                // A write lands at this same edge, so forward the captured data
                if (rw_r) begin
                    q_s = d_r;
                end else begin
                    q_s = rd_data_s;
                end
            end
            default: begin
                gnt_s  = 2'b00;
                busy_s = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture the winner and move the tie-break pointer away from it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r   <= 1'b0;
            owner_r <= 1'b0;
            rw_r    <= 1'b0;
            addr_r  <= {AW{1'b0}};
            d_r     <= {WIDTH{1'b0}};
        end else if ((state_r == IDLE) && take_s) begin
            ptr_r   <= ~win_s;
            owner_r <= win_s;
            rw_r    <= sel_rw_s;
            addr_r  <= sel_addr_s;
            d_r     <= sel_d_s;
        end
    end

    // Bank storage: a write commits on the STROBE -> DONE edge only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_r[i] <= {WIDTH{1'b0}};
            end
        end else if ((state_r == STROBE) && rw_r) begin
            bank_r[addr_r] <= d_r;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r  <= 2'b00;
            en_r   <= 1'b0;
            busy_r <= 1'b0;
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            q_r    <= {WIDTH{1'b0}};
        end else begin
            gnt_r  <= gnt_s;
            en_r   <= en_s;
            busy_r <= busy_s;
            ack0_r <= ack0_s;
            ack1_r <= ack1_s;
            q_r    <= q_s;
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.en   = en_r;
    assign bus.busy = busy_r;
    assign bus.ack0 = ack0_r;
    assign bus.ack1 = ack1_r;
    assign bus.q    = q_r;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with an ack-driven scoreboard.
module tb_reg_bank_arbiter;

    logic clk;
    logic rst_n;

    reg_bank_arbiter_if #(.WIDTH(8)) bus ();

    reg_bank_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         who;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int who);
        logic [1:0] r;
        r = (who == 0) ? 2'b01 : 2'b10;
        return r;
    endfunction

    task automatic set_req(input int who, input logic req, input logic rw,
                           input logic [1:0] addr, input logic [7:0] d);
        if (who == 0) begin
            bus.req0 = req; bus.rw0 = rw; bus.addr0 = addr; bus.d0 = d;
        end else begin
            bus.req1 = req; bus.rw1 = rw; bus.addr1 = addr; bus.d1 = d;
        end
    endtask

    // One full transaction with cycle-exact checks of en/gnt/ack/busy
    task automatic run_txn(input int who, input logic rw, input logic [1:0] addr,
                           input logic [7:0] d, input logic [7:0] exp_q, input bit corrupt);
        exp_t e;
        @(posedge clk); #1;
        set_req(who, 1'b1, rw, addr, d);
        e.who = who; e.q = exp_q;
        sb.push_back(e);
        @(posedge clk);                       // sampling edge
        @(negedge clk);                       // STROBE
        chk("strobe_en", {31'd0, bus.en}, 32'd1);
        chk("strobe_gnt", {30'd0, bus.gnt}, {30'd0, oh(who)});
        chk("strobe_noack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        if (corrupt) begin
            set_req(who, 1'b1, rw, addr, 8'hFF);
        end
        @(negedge clk);                       // DONE
        chk("done_ack", {30'd0, bus.ack1, bus.ack0}, {30'd0, oh(who)});
        chk("done_en", {31'd0, bus.en}, 32'd0);
        set_req(who, 1'b0, 1'b0, 2'd0, 8'd0);
        @(posedge clk);
        @(negedge clk);                       // IDLE
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_gnt", {30'd0, bus.gnt}, 32'd0);
    endtask

    // Scoreboard pop on ack plus per-cycle invariants
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
            chk("en_in_busy", {31'd0, bus.en & ~bus.busy}, 32'd0);
            if (bus.ack0 || bus.ack1) begin
                chk("ack_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_owner", {30'd0, bus.ack1, bus.ack0}, {30'd0, oh(e.who)});
                    chk("sb_q", {24'd0, bus.q}, {24'd0, e.q});
                end
            end else begin
                chk("q_zero_no_ack", {24'd0, bus.q}, 32'd0);
            end
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 2'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 2'd0, 8'd0);
        #3;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_outs", {19'd0, bus.gnt, bus.en, bus.ack0, bus.ack1, bus.q}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reads right after reset return zero, then idle quiet
        for (int a = 0; a < 4; a++) begin
            run_txn(a % 2, 1'b0, a[1:0], 8'd0, 8'h00, 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("idle_quiet", {21'd0, bus.gnt, bus.en, bus.busy, bus.q}, 32'd0);

        // Write then read back by the other requester
        run_txn(0, 1'b1, 2'd2, 8'hA5, 8'hA5, 1'b0);
        run_txn(1, 1'b0, 2'd2, 8'h00, 8'hA5, 1'b0);

        // Operand change during STROBE is ignored
        run_txn(0, 1'b1, 2'd1, 8'h3C, 8'h3C, 1'b1);
        run_txn(1, 1'b0, 2'd1, 8'h00, 8'h3C, 1'b0);

        // req0 held one cycle past ack starts a second transaction
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 2'd0, 8'h5A);
        e.who = 0; e.q = 8'h5A;
        sb.push_back(e); sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk("hold_en1", {31'd0, bus.en}, 32'd1);
        @(negedge clk);
        chk("hold_ack1", {31'd0, bus.ack0}, 32'd1);
        @(negedge clk);
        chk("hold_idle", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        chk("hold_en2", {31'd0, bus.en}, 32'd1);
        @(negedge clk);
        chk("hold_ack2", {31'd0, bus.ack0}, 32'd1);
        repeat (2) @(negedge clk);
        chk("hold_no_third", {31'd0, bus.busy}, 32'd0);

        // Reset in STROBE aborts a write
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 2'd3, 8'h77);
        @(posedge clk);
        @(negedge clk);
        chk("abort_en", {31'd0, bus.en}, 32'd1);
        #1;
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, 2'd0, 8'd0);
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_outs", {19'd0, bus.gnt, bus.en, bus.ack0, bus.ack1, bus.q}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        run_txn(1, 1'b0, 2'd3, 8'h00, 8'h00, 1'b0);
        run_txn(0, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0);

        // Continuous dual requests from reset release alternate 0,1,0,1
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b1, 2'd0, 8'h11);
        set_req(1, 1'b1, 1'b1, 2'd1, 8'h22);
        for (int i = 0; i < 4; i++) begin
            e.who = i % 2;
            e.q   = (i % 2 == 0) ? 8'h11 : 8'h22;
            sb.push_back(e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dual_gnt", {30'd0, bus.gnt}, {30'd0, oh(i % 2)});
            chk("dual_en", {31'd0, bus.en}, 32'd1);
            @(negedge clk);
            if (i == 3) begin
                set_req(0, 1'b0, 1'b0, 2'd0, 8'd0);
                set_req(1, 1'b0, 1'b0, 2'd0, 8'd0);
            end
            @(negedge clk);
            chk("dual_idle", {31'd0, bus.busy}, 32'd0);
        end
        repeat (3) @(negedge clk);
        chk("dual_stopped", {31'd0, bus.busy}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
